// File: rtl/mem_ws_ctrl.sv
// Single-port on-chip RAM slave for the picorv32 native memory bus, with its own
// address window decode and a configurable number of wait states before the access.
module mem_ws_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   offset;
    logic          sel;
    logic [AW-1:0] index;
    logic [31:0]   rd_word;
    logic [31:0]   ram [DEPTH_WORDS];
    logic          unused_bits;

    // Offset compare avoids overflow when the window ends at the top of the address space.
    assign offset = mem_addr - BASE_ADDR;
    assign sel    = mem_valid && (mem_addr >= BASE_ADDR) && (offset < SPAN);
    assign index  = offset[AW+1:2];

    assign unused_bits = ^{mem_instr, offset[1:0], offset[31:AW+2]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sel) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // Once here the transaction commits regardless of mem_valid.
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM has no reset so it can map onto block RAM; read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            rd_word <= ram[index];
            for (int n = 0; n < 4; n++) begin
                if (mem_wstrb[n]) begin
                    ram[index][8*n +: 8] <= mem_wdata[8*n +: 8];
                end
            end
        end
    end

    assign mem_ready = (state == RESP);
    assign mem_rdata = mem_ready ? rd_word : 32'h0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_ws_ctrl.sv
// Scoreboard bench for mem_ws_ctrl: three instances cover zero wait states,
// three wait states, and a small offset window.
module tb_mem_ws_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  valid;
    logic        instr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [2:0]  rdy;
    logic [2:0]  bsy;
    logic [31:0] rd [3];

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        bit          known;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    mem_ws_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(4096), .WAIT_STATES(0)) dut_a (
        .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_instr(instr),
        .mem_wstrb(wstrb), .mem_wdata(wdata), .mem_addr(addr),
        .mem_ready(rdy[0]), .mem_rdata(rd[0]), .busy(bsy[0]));

    mem_ws_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(4096), .WAIT_STATES(3)) dut_b (
        .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_instr(instr),
        .mem_wstrb(wstrb), .mem_wdata(wdata), .mem_addr(addr),
        .mem_ready(rdy[1]), .mem_rdata(rd[1]), .busy(bsy[1]));

    mem_ws_ctrl #(.BASE_ADDR(32'h0001_0000), .DEPTH_WORDS(16), .WAIT_STATES(0)) dut_c (
        .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_instr(instr),
        .mem_wstrb(wstrb), .mem_wdata(wdata), .mem_addr(addr),
        .mem_ready(rdy[2]), .mem_rdata(rd[2]), .busy(bsy[2]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic int wordKey(input int d, input logic [31:0] a);
        logic [31:0] base;
        base = (d == 2) ? 32'h0001_0000 : 32'h0;
        return d * 65536 + int'((a - base) >> 2);
    endfunction

    // One full request/response handshake; expected response is queued before driving.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] w, input bit ack, input int lat);
        exp_t        e;
        int          key;
        bit          got;
        logic [31:0] merged;
        key     = wordKey(d, a);
        e.d     = d;
        e.lat   = lat;
        e.known = model.exists(key);
        e.rdata = e.known ? model[key] : 32'h0;
        if (ack) begin
            exp_q.push_back(e);
            merged = e.rdata;
            for (int n = 0; n < 4; n++) begin
                if (s[n]) merged[8*n +: 8] = w[8*n +: 8];
            end
            if (s != 4'h0 && (e.known || s == 4'hF)) model[key] = merged;
        end
        @(posedge clk);
        #1;
        addr     = a;
        wstrb    = s;
        wdata    = w;
        valid[d] = 1'b1;
        got      = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (rdy[d]) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ready", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("latency", 32'(c), 32'(e.lat));
                    if (e.known) checkOutput("rdata", rd[d], e.rdata);
                end
            end else if (rd[d] !== 32'h0) begin
                checkOutput("rdata_idle_zero", rd[d], 32'h0);
            end
        end
        if (ack && !got) begin
            checkOutput("ack_timeout", 32'(got), 32'd1);
            void'(exp_q.pop_front());
        end
        if (!ack) checkOutput("no_ack", 32'(got), 32'd0);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        @(negedge clk);
        checkOutput("ready_one_cycle", 32'(rdy[d]), 32'd0);
        checkOutput("rdata_after_zero", rd[d], 32'h0);
        checkOutput("busy_idle", 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        valid  = 3'b111;
        instr  = 1'b0;
        wstrb  = 4'h0;
        wdata  = 32'h0;
        addr   = 32'h0001_0000;

        // Reset held with requests pending on every instance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_ready", 32'(rdy), 32'd0);
            checkOutput("reset_busy", 32'(bsy), 32'd0);
            checkOutput("reset_rdata_a", rd[0], 32'h0);
            checkOutput("reset_rdata_c", rd[2], 32'h0);
        end
        valid = 3'b000;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Full word write/read and byte lanes, no wait states.
        applyStimulus(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 2);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, 1'b1, 2);
        applyStimulus(0, 32'h10, 4'b0001, 32'h0000_00AA, 1'b1, 2);
        applyStimulus(0, 32'h10, 4'b1000, 32'h5500_0000, 1'b1, 2);
        checkOutput("byte_lane_model", model[wordKey(0, 32'h10)], 32'h55AD_BEAA);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, 1'b1, 2);

        // Three wait states: write, read back, then an aborted write.
        applyStimulus(1, 32'h40, 4'hF, 32'h1234_5678, 1'b1, 5);
        applyStimulus(1, 32'h40, 4'h0, 32'h0, 1'b1, 5);
        @(posedge clk);
        #1;
        addr     = 32'h40;
        wstrb    = 4'hF;
        wdata    = 32'hCAFE_F00D;
        valid[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            checkOutput("abort_no_ready", 32'(rdy[1]), 32'd0);
            if (c == 3) checkOutput("abort_busy_low", 32'(bsy[1]), 32'd0);
        end
        applyStimulus(1, 32'h40, 4'h0, 32'h0, 1'b1, 5);

        // Window decode on the offset instance.
        applyStimulus(2, 32'h0000_FFFC, 4'hF, 32'h1111_1111, 1'b0, 0);
        applyStimulus(2, 32'h0001_0000, 4'hF, 32'hA5A5_0001, 1'b1, 2);
        applyStimulus(2, 32'h0001_003C, 4'hF, 32'hA5A5_003C, 1'b1, 2);
        applyStimulus(2, 32'h0001_0040, 4'hF, 32'h2222_2222, 1'b0, 0);
        applyStimulus(2, 32'h0001_003C, 4'h0, 32'h0, 1'b1, 2);
        applyStimulus(2, 32'h0001_0003, 4'h0, 32'h0, 1'b1, 2);

        // Reset right after the ACCESS edge: write lands, ready never seen.
        @(posedge clk);
        #1;
        addr     = 32'h20;
        wstrb    = 4'hF;
        wdata    = 32'h0BAD_F00D;
        valid[0] = 1'b1;
        @(negedge clk);
        checkOutput("midrst_cycle0_ready", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_access_busy", 32'(bsy[0]), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(rdy[0]), 32'd0);
        checkOutput("midrst_busy", 32'(bsy[0]), 32'd0);
        valid[0] = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model[wordKey(0, 32'h20)] = 32'h0BAD_F00D;
        applyStimulus(0, 32'h20, 4'h0, 32'h0, 1'b1, 2);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
